// File: rtl/add16_seq.sv
// Two-requester 16-bit adder: round-robin arbitration, then a+b+ci computed
// nibble-serially on one shared 4-bit adder slice (4 CALC cycles, 1 DONE cycle).
module add16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic        ci0,
   input  logic        req1,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic        ci1,
   output logic [1:0]  gnt,
   output logic        busy,
   output logic        done,
   output logic [15:0] s,
   output logic        co,
   output logic        done_id
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic        carry_q, carry_d;
   logic        owner_q, owner_d;
   logic        ptr_q, ptr_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        co_q, co_d;
   logic        done_id_q, done_id_d;

   logic        win;
   logic [3:0]  nib_a, nib_b, nib_sum;
   logic        nib_co;

   // On a tie the requester not granted last wins; ptr_q holds the last grant.
   always_comb begin
      if (req0 && req1) win = ~ptr_q;
      else              win = req1;
   end

   always_comb begin
      nib_a = a_q[{idx_q, 2'b00} +: 4];
      nib_b = b_q[{idx_q, 2'b00} +: 4];
      {nib_co, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      carry_d   = carry_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      gnt_d     = '0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      co_d      = co_q;
      done_id_d = done_id_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = win;
               ptr_d   = win;
               a_d     = win ? a1 : a0;
               b_d     = win ? b1 : b0;
               carry_d = win ? ci1 : ci0;
               idx_d   = '0;
               gnt_d   = win ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            case (idx_q)
               2'd0:    s_d[3:0]   = nib_sum;
               2'd1:    s_d[7:4]   = nib_sum;
               2'd2:    s_d[11:8]  = nib_sum;
               default: s_d[15:12] = nib_sum;
            endcase
            carry_d = nib_co;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d   = DONE;
               co_d      = nib_co;
               done_d    = 1'b1;
               done_id_d = owner_q;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         carry_q   <= 1'b0;
         owner_q   <= 1'b0;
         ptr_q     <= 1'b1;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         co_q      <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         s_q       <= s_d;
         carry_q   <= carry_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         co_q      <= co_d;
         done_id_q <= done_id_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign s       = s_q;
   assign co      = co_q;
   assign done_id = done_id_q;

endmodule

// File: tb/tb_add16_seq.sv
// Directed, table-driven bench for add16_seq with hand-computed results,
// plus sequences for round-robin ties, busy-time requests and mid-op reset.
module tb_add16_seq;

   logic        clk, rst_n;
   logic        req0, ci0, req1, ci1;
   logic [15:0] a0, b0, a1, b1;
   logic [1:0]  gnt;
   logic        busy, done, co, done_id;
   logic [15:0] s;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   add16_seq dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
      .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
      .gnt(gnt), .busy(busy), .done(done), .s(s), .co(co), .done_id(done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          id;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] es;
      logic        eco;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt();
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         if (gnt != 2'b00) got = 1;
      end
   endtask

   // Returns number of edges from the call until done (0 if never seen).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done) lat = k;
      end
   endtask

   task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es, input logic eco);
      int lat;
      @(negedge clk);
      if (id) begin req1 = 1; a1 = a; b1 = b; ci1 = ci; end
      else    begin req0 = 1; a0 = a; b0 = b; ci0 = ci; end
      wait_gnt();
      check("op_gnt", {30'd0, gnt}, id ? 32'd2 : 32'd1);
      check("op_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      // scramble operands after capture: result must not change
      req0 = 0; req1 = 0; a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; ci0 = ~ci0; ci1 = ~ci1;
      wait_done(lat);
      check("op_latency", lat, 32'd4);
      check("op_s", {16'd0, s}, {16'd0, es});
      check("op_co", {31'd0, co}, {31'd0, eco});
      check("op_done_id", {31'd0, done_id}, {31'd0, id});
      @(posedge clk); #1;
      check("op_done_pulse", {31'd0, done}, 32'd0);
      check("op_busy_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int ng, nd, lat;
      int unsigned last;
      bit exp_id;

      vecs[0] = '{0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[3] = '{1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[6] = '{0, 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

      rst_n = 0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; ci0 = 0; ci1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", {30'd0, gnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_s", {16'd0, s}, 32'd0);
      check("rst_co", {31'd0, co}, 32'd0);
      check("rst_done_id", {31'd0, done_id}, 32'd0);
      @(negedge clk); rst_n = 1;

      // Tie after reset: 0 wins first, then alternate every 6 cycles.
      @(negedge clk);
      req0 = 1; a0 = 16'h0001; b0 = 16'h0002; ci0 = 0;
      req1 = 1; a1 = 16'h0010; b1 = 16'h0020; ci1 = 1;
      ng = 0; nd = 0; last = 0; exp_id = 0;
      for (int c = 0; c < 40 && nd < 3; c++) begin
         @(posedge clk); #1;
         if (gnt != 2'b00) begin
            check("rr_gnt", {30'd0, gnt}, exp_id ? 32'd2 : 32'd1);
            if (ng > 0) check("rr_spacing", cyc - last, 32'd6);
            last = cyc; ng++; exp_id = ~exp_id;
            if (ng == 3) begin @(negedge clk); req0 = 0; req1 = 0; end
         end
         if (done) begin
            check("rr_done_id", {31'd0, done_id}, nd % 2);
            check("rr_s", {16'd0, s}, (nd % 2 == 1) ? 32'h0031 : 32'h0003);
            nd++;
         end
      end
      check("rr_grants", ng, 32'd3);
      check("rr_dones", nd, 32'd3);

      foreach (vecs[i])
         do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].es, vecs[i].eco);

      // req1 raised during requester 0's CALC: no grant until back in IDLE.
      @(negedge clk);
      req0 = 1; a0 = 16'h1111; b0 = 16'h2222; ci0 = 0;
      wait_gnt();
      check("busy_req_gnt0", {30'd0, gnt}, 32'd1);
      @(negedge clk); req0 = 0;
      @(posedge clk); #1;
      @(negedge clk); req1 = 1; a1 = 16'h00FF; b1 = 16'h0001; ci1 = 0;
      for (int k = 2; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 4) begin
            check("busy_req_done", {31'd0, done}, 32'd1);
            check("busy_req_s0", {16'd0, s}, 32'h3333);
            check("busy_req_id0", {31'd0, done_id}, 32'd0);
         end
         if (k < 6) check("busy_req_nognt", {30'd0, gnt}, 32'd0);
         else       check("busy_req_gnt1", {30'd0, gnt}, 32'd2);
      end
      @(negedge clk); req1 = 0;
      wait_done(lat);
      check("busy_req_lat1", lat, 32'd4);
      check("busy_req_s1", {16'd0, s}, 32'h0100);
      check("busy_req_id1", {31'd0, done_id}, 32'd1);

      // Reset two CALC edges into an operation.
      @(negedge clk);
      req0 = 1; a0 = 16'h7777; b0 = 16'h0001; ci0 = 0;
      wait_gnt();
      @(negedge clk); req0 = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0; #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_s", {16'd0, s}, 32'd0);
      check("mid_rst_co", {31'd0, co}, 32'd0);
      check("mid_rst_id", {31'd0, done_id}, 32'd0);
      @(negedge clk); rst_n = 1;
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      check("mid_rst_no_done", nd, 32'd0);
      do_op(0, 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add16_seq.md
ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 req0  input  1  requester 0 operation request; held until gnt[0].
REQ-004 a0, b0  input  16 each  requester 0 operands; stable while req0 high.
REQ-005 ci0  input  1  requester 0 carry-in.
REQ-006 req1, a1, b1, ci1  input  1/16/16/1  requester 1 equivalents.
REQ-007 gnt  output  2  one-hot one-cycle grant pulse; bit n means requester n's operands were captured.
REQ-008 busy  output  1  high from capture edge until return to IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 s  output  16  sum result.
REQ-011 co  output  1  carry-out of bit 15.
REQ-012 done_id  output  1  requester index owning current s/co.

Function
REQ-013 Block SHALL time-share one internal 4-bit adder slice (nibble + nibble + carry -> nibble + carry) to compute 16-bit a+b+ci nibble-serially, LSB nibble first.
REQ-014 FSM states SHALL be IDLE, CALC, DONE; no other reachable states.
REQ-015 IDLE: on an edge with req0|req1 high, SHALL capture granted requester's a, b, ci into internal registers, set nibble index to 0, register gnt one-hot, set busy, go to CALC.
REQ-016 IDLE with no request SHALL stay IDLE; gnt=0.
REQ-017 Arbitration SHALL be round-robin: single request wins; if both, winner is requester not most recently granted; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-018 CALC: each edge SHALL write nibble sum to s[4*idx+3:4*idx], update carry register from slice carry-out, increment idx (2-bit).
REQ-019 After nibble idx=3 written, SHALL go to DONE, register co=final carry, assert done for exactly one cycle, done_id=granted index.
REQ-020 Latency: done SHALL rise 4 cycles after capture edge; DONE -> IDLE unconditionally next edge; minimum spacing between captures 6 cycles.
REQ-021 Requests present in CALC or DONE SHALL be ignored (no gnt) and served only once IDLE; a req held after its gnt SHALL be treated as a new request.
REQ-022 Result: {co, s} SHALL equal a + b + ci (17-bit, no saturation).
REQ-023 s, co, done_id SHALL hold last result until next done; partially written s during CALC is not valid and SHALL not be flagged by done.
REQ-024 Operand changes on request inputs after capture SHALL not affect the in-flight result.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, idx 0, gnt 0, busy 0, done 0, s 0x0000, co 0, done_id 0, carry register 0, pointer 1.
REQ-026 Reset mid-operation SHALL discard the partial result; no done pulse SHALL follow; first request after release served normally.
REQ-027 After rst_n deasserts, first capture SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-028 req0, a0=0x1234, b0=0x4321, ci0=0 -> gnt=01 one cycle, done 4 cycles after capture, s=0x5555, co=0, done_id=0.
REQ-029 req1, a1=0xFFFF, b1=0x0001, ci1=0 -> s=0x0000, co=1, done_id=1 (carry crosses all nibbles).
REQ-030 req0, a0=0xFFFF, b0=0xFFFF, ci0=1 -> s=0xFFFF, co=1.
REQ-031 After reset req0 and req1 held high together -> grants 01, 10, 01 alternating, each 6 cycles apart, done_id following.
REQ-032 req1 raised during CALC of requester 0 -> no gnt until IDLE; gnt=10 on first IDLE edge; requester 0 result unchanged.
REQ-033 rst_n pulsed low after 2 CALC edges -> busy, done, s, co all 0 at once; no done pulse; subsequent req0 0x0008+0x0008 -> s=0x0010, co=0.
